// File: rtl/vga_mode_loader_if.sv
// AXI4-Lite write-only channel between the mode loader and the VGA core register slave.
interface vga_mode_loader_if;
  logic        reg_awvalid;
  logic        reg_awready;
  logic [11:0] reg_awaddr;
  logic        reg_wvalid;
  logic        reg_wready;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_bvalid;
  logic        reg_bready;
  logic [1:0]  reg_bresp;

  modport master (
    output reg_awvalid, reg_awaddr, reg_wvalid, reg_wdata, reg_wstrb, reg_bready,
    input  reg_awready, reg_wready, reg_bvalid, reg_bresp
  );

  modport slave (
    input  reg_awvalid, reg_awaddr, reg_wvalid, reg_wdata, reg_wstrb, reg_bready,
    output reg_awready, reg_wready, reg_bvalid, reg_bresp
  );
endinterface

// File: rtl/vga_mode_loader.sv
// Replays an eight-write register sequence for one of three VGA modes over
// AXI4-Lite, ending with the VGA_LOAD_MODE write that commits the new timing.
module vga_mode_loader #(
  parameter int TIMEOUT     = 1024,
  parameter int PITCH_ALIGN = 16
) (
  input  logic              reg_clk,
  input  logic              reg_reset,
  input  logic              mode_start,
  input  logic [2:0]        mode_sel,
  input  logic [31:0]       disp_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        cur_mode,
  vga_mode_loader_if.master regs
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, DONE} state_t;
  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  // 1 bpp: one byte per 8 pixels, then padded up to the line alignment
  function automatic logic [12:0] pitch_of(input logic [11:0] hw);
    logic [12:0] bytes;
    bytes = ({1'b0, hw} + 13'd7) >> 3;
    return ((bytes + 13'(PITCH_ALIGN - 1)) / 13'(PITCH_ALIGN)) * 13'(PITCH_ALIGN);
  endfunction

  function automatic wr_t wr_of(input logic [2:0] m, input logic [2:0] i, input logic [31:0] fb);
    logic [11:0] hs, hw, hy, ht, vs, vw, vy, vt;
    logic [1:0]  pol;
    wr_t         w;
    case (m)
      3'd1: begin
        hs = 12'd87;  hw = 12'd800;  hy = 12'd128; ht = 12'd1055;
        vs = 12'd22;  vw = 12'd600;  vy = 12'd4;   vt = 12'd627;  pol = 2'b11;
      end
      3'd2: begin
        hs = 12'd159; hw = 12'd1024; hy = 12'd136; ht = 12'd1343;
        vs = 12'd28;  vw = 12'd768;  vy = 12'd6;   vt = 12'd805;  pol = 2'b00;
      end
      default: begin
        hs = 12'd47;  hw = 12'd640;  hy = 12'd96;  ht = 12'd799;
        vs = 12'd31;  vw = 12'd480;  vy = 12'd2;   vt = 12'd524;  pol = 2'b00;
      end
    endcase
    case (i)
      3'd0:    w = '{12'h000, {4'b0, hw, 4'b0, hs}, 4'hF};
      3'd1:    w = '{12'h004, {4'b0, ht, 4'b0, hy}, 4'hF};
      3'd2:    w = '{12'h008, {4'b0, vw, 4'b0, vs}, 4'hF};
      3'd3:    w = '{12'h00C, {4'b0, vt, 4'b0, vy}, 4'hF};
      3'd4:    w = '{12'h010, {30'b0, pol}, 4'h1};
      3'd5:    w = '{12'h100, fb, 4'hF};
      3'd6:    w = '{12'h104, {19'b0, pitch_of(hw)}, 4'h3};
      default: w = '{12'h108, 32'h1, 4'h1};
    endcase
    return w;
  endfunction

  state_t        state;
  logic [2:0]    idx, mode_q;
  logic [31:0]   disp_q;
  logic          aw_ok, w_ok;
  logic [CW-1:0] cnt;
  wr_t           nxt;
  logic          aw_hs, w_hs, timeout;

  assign aw_hs   = regs.reg_awvalid & regs.reg_awready;
  assign w_hs    = regs.reg_wvalid & regs.reg_wready;
  assign timeout = (state == ISSUE || state == WAIT_B) && cnt == CW'(TIMEOUT - 1);

  // Next write: first one comes straight from the request inputs, later ones from the latches
  always_comb begin
    nxt = wr_of(mode_q, idx + 3'd1, disp_q);
    if (state == IDLE) nxt = wr_of(mode_sel, 3'd0, disp_addr);
  end

  always_ff @(posedge reg_clk) begin
    if (reg_reset) begin
      state            <= IDLE;
      idx              <= '0;
      mode_q           <= '0;
      disp_q           <= '0;
      aw_ok            <= 1'b0;
      w_ok             <= 1'b0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      cur_mode         <= '0;
      regs.reg_awvalid <= 1'b0;
      regs.reg_awaddr  <= '0;
      regs.reg_wvalid  <= 1'b0;
      regs.reg_wdata   <= '0;
      regs.reg_wstrb   <= '0;
      regs.reg_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + CW'(1);
      case (state)
        IDLE: if (mode_start) begin
          mode_q <= mode_sel;
          disp_q <= disp_addr;
          busy   <= 1'b1;
          error  <= 1'b0;
          idx    <= '0;
          if (mode_sel > 3'd2) begin
            error <= 1'b1;
            state <= DONE;
          end else begin
            state            <= ISSUE;
            cnt              <= '0;
            aw_ok            <= 1'b0;
            w_ok             <= 1'b0;
            regs.reg_awvalid <= 1'b1;
            regs.reg_wvalid  <= 1'b1;
            regs.reg_awaddr  <= nxt.addr;
            regs.reg_wdata   <= nxt.data;
            regs.reg_wstrb   <= nxt.strb;
          end
        end
        ISSUE: if (timeout) begin
          regs.reg_awvalid <= 1'b0;
          regs.reg_wvalid  <= 1'b0;
          error            <= 1'b1;
          state            <= DONE;
        end else begin
          if (aw_hs) begin regs.reg_awvalid <= 1'b0; aw_ok <= 1'b1; end
          if (w_hs)  begin regs.reg_wvalid  <= 1'b0; w_ok  <= 1'b1; end
          if ((aw_ok | aw_hs) && (w_ok | w_hs)) begin
            regs.reg_bready <= 1'b1;
            state           <= WAIT_B;
          end
        end
        WAIT_B: if (timeout) begin
          regs.reg_bready <= 1'b0;
          error           <= 1'b1;
          state           <= DONE;
        end else if (regs.reg_bvalid) begin
          regs.reg_bready <= 1'b0;
          if (regs.reg_bresp != 2'b00) begin
            error <= 1'b1;
            state <= DONE;
          end else if (idx == 3'd7) begin
            state <= DONE;
          end else begin
            idx              <= idx + 3'd1;
            state            <= ISSUE;
            cnt              <= '0;
            aw_ok            <= 1'b0;
            w_ok             <= 1'b0;
            regs.reg_awvalid <= 1'b1;
            regs.reg_wvalid  <= 1'b1;
            regs.reg_awaddr  <= nxt.addr;
            regs.reg_wdata   <= nxt.data;
            regs.reg_wstrb   <= nxt.strb;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (!error) cur_mode <= mode_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_mode_loader.sv
// Bench for vga_mode_loader: table-driven mode loads against a scripted AXI-Lite
// slave, plus hand-written timeout and mid-sequence reset sequences.
module tb_vga_mode_loader;
  logic        clk = 1'b0;
  logic        rst, mode_start, busy, done, error;
  logic [2:0]  mode_sel, cur_mode;
  logic [31:0] disp_addr;

  vga_mode_loader_if bus();

  vga_mode_loader #(.TIMEOUT(16), .PITCH_ALIGN(16)) dut (
    .reg_clk(clk), .reg_reset(rst), .mode_start(mode_start), .mode_sel(mode_sel),
    .disp_addr(disp_addr), .busy(busy), .done(done), .error(error),
    .cur_mode(cur_mode), .regs(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] fb;
    bit          alt;
    int          err_idx;
    int          n_exp;
    bit          exp_err;
    logic [2:0]  exp_cur;
  } vec_t;

  vec_t vecs[6];

  int hs_t[3]    = '{47, 87, 159};
  int hw_t[3]    = '{640, 800, 1024};
  int hy_t[3]    = '{96, 128, 136};
  int ht_t[3]    = '{799, 1055, 1343};
  int vs_t[3]    = '{31, 22, 28};
  int vw_t[3]    = '{480, 600, 768};
  int vy_t[3]    = '{2, 4, 6};
  int vt_t[3]    = '{524, 627, 805};
  int pol_t[3]   = '{0, 3, 0};
  int pitch_t[3] = '{80, 112, 128};

  int n_chk = 0, n_fail = 0;
  logic [47:0] expq[$];

  // slave state
  bit          alt, b_never, aw_got, w_got, paired, any_valid;
  int          err_idx, nwr, aw_wait, w_wait;
  logic [11:0] cap_a, prev_a;
  logic [31:0] cap_d;
  logic [3:0]  cap_s;
  logic [35:0] prev_w;

  function automatic logic [47:0] exp_wr(input int m, input int i, input logic [31:0] fb);
    case (i)
      0: return {12'h000, 4'h0, 12'(hw_t[m]), 4'h0, 12'(hs_t[m]), 4'hF};
      1: return {12'h004, 4'h0, 12'(ht_t[m]), 4'h0, 12'(hy_t[m]), 4'hF};
      2: return {12'h008, 4'h0, 12'(vw_t[m]), 4'h0, 12'(vs_t[m]), 4'hF};
      3: return {12'h00C, 4'h0, 12'(vt_t[m]), 4'h0, 12'(vy_t[m]), 4'hF};
      4: return {12'h010, 32'(pol_t[m]), 4'h1};
      5: return {12'h100, fb, 4'hF};
      6: return {12'h104, 32'(pitch_t[m]), 4'h3};
      7: return {12'h108, 32'h1, 4'h1};
      default: return 48'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  // Slave decides its readies mid-cycle; a ready raised here completes on the next posedge.
  task automatic slave_step();
    int ad, wd;
    ad = alt ? ((nwr % 2 == 1) ? 3 : 0) : 0;
    wd = alt ? ((nwr % 2 == 1) ? 0 : 3) : 0;
    if (rst) begin
      bus.reg_awready = 1'b0; bus.reg_wready = 1'b0;
      bus.reg_bvalid  = 1'b0; bus.reg_bresp  = 2'b00;
      aw_got = 1'b0; w_got = 1'b0; paired = 1'b0; aw_wait = 0; w_wait = 0;
      return;
    end
    if (bus.reg_awvalid || bus.reg_wvalid) any_valid = 1'b1;
    bus.reg_awready = 1'b0;
    if (aw_got) chk("aw_drop", bus.reg_awvalid, 0);
    else if (bus.reg_awvalid) begin
      if (aw_wait > 0) chk("aw_stable", bus.reg_awaddr, prev_a);
      prev_a = bus.reg_awaddr;
      if (aw_wait >= ad) begin
        bus.reg_awready = 1'b1; aw_got = 1'b1; cap_a = bus.reg_awaddr; aw_wait = 0;
      end else aw_wait++;
    end
    bus.reg_wready = 1'b0;
    if (w_got) chk("w_drop", bus.reg_wvalid, 0);
    else if (bus.reg_wvalid) begin
      if (w_wait > 0) chk("w_stable", {bus.reg_wdata, bus.reg_wstrb}, prev_w);
      prev_w = {bus.reg_wdata, bus.reg_wstrb};
      if (w_wait >= wd) begin
        bus.reg_wready = 1'b1; w_got = 1'b1;
        cap_d = bus.reg_wdata; cap_s = bus.reg_wstrb; w_wait = 0;
      end else w_wait++;
    end
    bus.reg_bvalid = 1'b0;
    bus.reg_bresp  = 2'b00;
    if (aw_got && w_got) begin
      if (!paired) begin
        paired = 1'b1;
        chk("write_expected", expq.size() > 0, 1);
        if (expq.size() > 0) chk($sformatf("write%0d", nwr), {cap_a, cap_d, cap_s}, expq.pop_front());
      end
      if (bus.reg_bready && !b_never) begin
        bus.reg_bvalid = 1'b1;
        bus.reg_bresp  = (nwr == err_idx) ? 2'b10 : 2'b00;
        nwr++; aw_got = 1'b0; w_got = 1'b0; paired = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic start(input logic [2:0] m, input logic [31:0] fb);
    mode_sel = m; disp_addr = fb; mode_start = 1'b1;
    tick();
    mode_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    chk("done_seen", done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    alt = v.alt; err_idx = v.err_idx; nwr = 0; any_valid = 1'b0;
    for (int i = 0; i < v.n_exp; i++) expq.push_back(exp_wr(int'(v.mode), i, v.fb));
    start(v.mode, v.fb);
    if (v.n_exp == 0) begin
      chk("inv_busy", busy, 1);
      chk("inv_done_early", done, 0);
    end
    wait_done(cyc);
    if (v.n_exp == 0) begin
      chk("inv_latency", cyc, 1);
      chk("inv_no_valid", any_valid, 0);
    end
    chk("error", error, v.exp_err);
    chk("cur_mode", cur_mode, v.exp_cur);
    chk("busy_at_done", busy, 0);
    chk("write_count", nwr, v.n_exp);
    chk("queue_empty", expq.size(), 0);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_bus", {bus.reg_awvalid, bus.reg_wvalid, bus.reg_bready}, 0);
    chk("error_held", error, v.exp_err);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{3'd0, 32'h0010_0000, 1'b0, -1, 8, 1'b0, 3'd0};
    vecs[1] = '{3'd1, 32'h2000_0000, 1'b1, -1, 8, 1'b0, 3'd1};
    vecs[2] = '{3'd2, 32'h0300_0040, 1'b0,  3, 4, 1'b1, 3'd1};
    vecs[3] = '{3'd5, 32'h0000_0000, 1'b0, -1, 0, 1'b1, 3'd1};
    vecs[4] = '{3'd2, 32'h1234_5600, 1'b1, -1, 8, 1'b0, 3'd2};
    vecs[5] = '{3'd7, 32'h0000_0000, 1'b0, -1, 0, 1'b1, 3'd2};

    rst = 1'b1; mode_start = 1'b0; mode_sel = '0; disp_addr = '0;
    alt = 1'b0; b_never = 1'b0; err_idx = -1; nwr = 0; any_valid = 1'b0;
    aw_got = 1'b0; w_got = 1'b0; paired = 1'b0; aw_wait = 0; w_wait = 0;
    repeat (3) tick();
    chk("rst_status", {busy, done, error}, 0);
    chk("rst_cur_mode", cur_mode, 0);
    chk("rst_valids", {bus.reg_awvalid, bus.reg_wvalid, bus.reg_bready}, 0);
    chk("rst_awaddr", bus.reg_awaddr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_wstrb", bus.reg_wstrb, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Slave never responds: bready drops 16 edges after ISSUE entry, done follows
    b_never = 1'b1; alt = 1'b0; err_idx = -1; nwr = 0;
    expq.push_back(exp_wr(0, 0, 32'h0));
    start(3'd0, 32'h0);
    repeat (15) tick();
    chk("to_bready_hold", bus.reg_bready, 1);
    chk("to_error_early", error, 0);
    tick();
    chk("to_bready_drop", bus.reg_bready, 0);
    chk("to_error", error, 1);
    chk("to_done_early", done, 0);
    chk("to_valids", {bus.reg_awvalid, bus.reg_wvalid}, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_busy", busy, 0);
    chk("to_cur_mode", cur_mode, 2);
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0; b_never = 1'b0; expq.delete(); nwr = 0;
    tick();

    // Reset while write idx 4 is on the bus
    for (int i = 0; i < 8; i++) expq.push_back(exp_wr(0, i, 32'h0020_0000));
    start(3'd0, 32'h0020_0000);
    cyc = 0;
    while (!(bus.reg_awvalid && bus.reg_awaddr == 12'h010) && cyc < 100) begin tick(); cyc++; end
    chk("reach_idx4", cyc < 100, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valids", {bus.reg_awvalid, bus.reg_wvalid, bus.reg_bready}, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b0; expq.delete(); nwr = 0;
    tick();

    // Fresh load with stray starts while busy
    for (int i = 0; i < 8; i++) expq.push_back(exp_wr(0, i, 32'h0040_0000));
    start(3'd0, 32'h0040_0000);
    repeat (4) tick();
    start(3'd1, 32'hDEAD_0000);
    repeat (4) tick();
    start(3'd6, 32'h0);
    wait_done(cyc);
    chk("ign_error", error, 0);
    chk("ign_cur_mode", cur_mode, 0);
    chk("ign_write_count", nwr, 8);
    chk("ign_queue_empty", expq.size(), 0);
    repeat (4) tick();
    chk("ign_no_requeue", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
